// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: one log-shift stage per register, SHW stages, valid/ready on both sides.
// Define PIPE_SHIFTER_FLAGS_EN to add the out_zero / out_carry result flags.
module pipe_shifter #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SHIFTER_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Stage registers; control fields are only needed by the stages that still have to shift.
  logic [WIDTH-1:0] data_reg [SHW];
  logic [SHW-1:0]   valid_reg;
  logic [SHW-1:0]   amt_reg  [SHW-1];
  logic [2:0]       op_reg   [SHW-1];
  logic [SHW-2:0]   sign_reg;

  // Stage inputs (previous register or the block inputs) and the shifted next value.
  logic [WIDTH-1:0] stg_data [SHW];
  logic [SHW-1:0]   stg_amt  [SHW];
  logic [2:0]       stg_op   [SHW];
  logic [SHW-1:0]   stg_sign;
  logic [SHW-1:0]   stg_valid;
  logic [WIDTH-1:0] nxt_data [SHW];

  logic stall;

  function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] d, input logic sign,
                                                input logic [2:0] op, input logic en, input int s);
    logic [WIDTH-1:0] ones;
    ones = '1;
    shift_fn = d;
    if (en) begin
      case (op)
        OP_SLL:  shift_fn = d << s;
        OP_SRL:  shift_fn = d >> s;
        OP_SRA:  shift_fn = (d >> s) | (sign ? ~(ones >> s) : '0);
        OP_ROL:  shift_fn = (d << s) | (d >> (WIDTH - s));
        OP_ROR:  shift_fn = (d >> s) | (d << (WIDTH - s));
        default: shift_fn = d;
      endcase
    end
  endfunction

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = valid_reg[SHW-1];
  assign out_data  = data_reg[SHW-1];

  genvar gi;
  generate
    for (gi = 0; gi < SHW; gi++) begin : g_stage
      if (gi == 0) begin : g_in
        assign stg_data[gi]  = in_data;
        assign stg_amt[gi]   = in_amt;
        assign stg_op[gi]    = in_op;
        assign stg_sign[gi]  = in_data[WIDTH-1];
        assign stg_valid[gi] = in_valid;
      end else begin : g_pipe
        assign stg_data[gi]  = data_reg[gi-1];
        assign stg_amt[gi]   = amt_reg[gi-1];
        assign stg_op[gi]    = op_reg[gi-1];
        assign stg_sign[gi]  = sign_reg[gi-1];
        assign stg_valid[gi] = valid_reg[gi-1];
      end
      // Remaining amount is kept right-aligned, so bit 0 always selects this stage's shift.
      assign nxt_data[gi] = shift_fn(stg_data[gi], stg_sign[gi], stg_op[gi], stg_amt[gi][0], 1 << gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) data_reg[k] <= '0;
      valid_reg <= '0;
      for (int k = 0; k < SHW - 1; k++) begin
        amt_reg[k] <= '0;
        op_reg[k]  <= '0;
      end
      sign_reg <= '0;
    end else if (!stall) begin
      for (int k = 0; k < SHW; k++) data_reg[k] <= nxt_data[k];
      valid_reg <= stg_valid;
      for (int k = 0; k < SHW - 1; k++) begin
        amt_reg[k]  <= stg_amt[k] >> 1;
        op_reg[k]   <= stg_op[k];
        sign_reg[k] <= stg_sign[k];
      end
    end
  end

`ifdef PIPE_SHIFTER_FLAGS_EN
  logic [SHW-1:0] carry_reg;
  logic [SHW-1:0] stg_carry;
  logic [SHW-1:0] nxt_carry;
  logic           zero_reg;

  // The last stage that actually shifts decides which bit crossed the boundary last.
  function automatic logic carry_fn(input logic [WIDTH-1:0] d, input logic [2:0] op,
                                    input logic en, input logic cin, input int s);
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    hi = d >> (WIDTH - s);
    lo = d >> (s - 1);
    carry_fn = cin;
    if (en) begin
      case (op)
        OP_SLL, OP_ROL:         carry_fn = hi[0];
        OP_SRL, OP_SRA, OP_ROR: carry_fn = lo[0];
        default:                carry_fn = cin;
      endcase
    end
  endfunction

  generate
    for (gi = 0; gi < SHW; gi++) begin : g_flag
      if (gi == 0) begin : g_in
        assign stg_carry[gi] = 1'b0;
      end else begin : g_pipe
        assign stg_carry[gi] = carry_reg[gi-1];
      end
      assign nxt_carry[gi] = carry_fn(stg_data[gi], stg_op[gi], stg_amt[gi][0], stg_carry[gi], 1 << gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_reg <= '0;
      zero_reg  <= 1'b0;
    end else if (!stall) begin
      carry_reg <= nxt_carry;
      zero_reg  <= ~|nxt_data[SHW-1];
    end
  end

  assign out_zero  = zero_reg;
  assign out_carry = carry_reg[SHW-1];
`endif

endmodule

// File: doc/pipe_shifter.md
Name: pipe_shifter

Overview:
- Parametrised, pipelined successor to the team's 16-bit combinational barrel shifter.
- Supports logical left, logical right, arithmetic right, rotate left and rotate right on a WIDTH-bit operand.
- One log-shift stage per register, with a valid/ready handshake on input and output.
- Sits between the ALU operand mux and the writeback register, replacing the combinational shifter where timing requires pipelining.

Parameters:
- WIDTH, 16, operand width; power of two, minimum 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0..WIDTH-1.
- in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.

Behaviour:
- Pipeline has SHW register stages. Stage k applies a shift of 2^k when in_amt[k]=1; otherwise it passes the data through.
- Each stage carries: data, remaining amount bits, op, valid.
- Latency: exactly SHW cycles from acceptance to out_valid, absent stalls. Throughput: one operand per cycle.
- Accept condition: in_valid && in_ready.
- stall = out_valid && !out_ready.
  - in_ready = !stall.
  - On stall the whole pipeline holds; no stage advances.
  - When not stalled, every stage advances; empty slots propagate as bubbles (valid=0).
- Output register is the final stage. out_data and out_valid hold stable while stalled. Result transfers on out_valid && out_ready.
- Fill bits by op:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: copies of the original operand MSB enter at the MSB. The sign bit is captured at acceptance and carried down the pipe.
  - ROL/ROR: bits leaving one end re-enter at the other.
- No arithmetic-left op; SLL covers it.
- Amount 0: out_data = in_data for every op.
- Amount WIDTH-1: SRL of MSB-only operand yields 1; SLL of LSB-only operand yields MSB-only.
- Reserved op (101-111): out_data = in_data unchanged, with the same latency and handshake.
- Ordering: results leave in acceptance order. No reordering, no drops.
- Reset: all stage valids 0, all stage data 0, out_valid=0, out_data=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: all in-flight operands are discarded; none appear at the output.
- Simultaneous output transfer and input acceptance in the same cycle is legal. Full throughput is sustained when out_ready is held high.
- out_ready low while out_valid=0: no stall. Bubbles may be filled.

Optional Feature:
- Macro: PIPE_SHIFTER_FLAGS_EN.
- Defined: adds two outputs.
  - out_zero (1 bit): result == 0.
  - out_carry (1 bit): last bit shifted out.
- out_carry rules:
  - SLL: bit in_data[WIDTH-amt].
  - SRL/SRA: bit in_data[amt-1].
  - Rotates: the last bit moved across the boundary (equal to result LSB for ROL, result MSB for ROR).
  - Amount 0 or reserved op: 0.
- Flags are pipelined alongside data, aligned with out_valid, reset to 0, and held stable on stall.
- Not defined: ports and flag logic are absent; behaviour is otherwise identical.

Test Plan:
- WIDTH=16, SLL 0x8001 amt 1 -> out_data 0x0002 after 4 cycles; out_carry=1 with flags.
- SRA 0x8000 amt 4 -> 0xF800; SRL 0x8000 amt 4 -> 0x0800; SRL 0x8000 amt 15 -> 0x0001.
- ROR 0x0001 amt 1 -> 0x8000; ROL 0x8001 amt 4 -> 0x0018; any op amt 0 on 0xA5C3 -> 0xA5C3; op 111 on 0x1234 amt 3 -> 0x1234.
- Backpressure: 6 back-to-back SLL by 1 of values 1..6, out_ready low for 3 cycles mid-stream.
  - in_ready low exactly while stalled.
  - Outputs 2,4,6,8,10,12 in order, none lost or duplicated, out_data stable during stall.
- Reset mid-flight: accept 3 operands, assert rst one cycle.
  - out_valid stays 0 until a new operand is accepted.
  - Next result appears 4 cycles after its acceptance.
- Random sweep against a reference model for WIDTH=8, 16 and 32, with random in_valid/out_ready: all results match in order.
